// File: rtl/branch_comp_arbiter_if.sv
// Request/response bundle for the shared branch comparator.
// master = requesters + consumer, slave = arbiter.
interface branch_comp_arbiter_if #(
    parameter int XLEN = 32
);
    logic            req0_valid;
    logic            req0_ready;
    logic [XLEN-1:0] req0_a;
    logic [XLEN-1:0] req0_b;
    logic [2:0]      req0_funct3;
    logic            req1_valid;
    logic            req1_ready;
    logic [XLEN-1:0] req1_a;
    logic [XLEN-1:0] req1_b;
    logic [2:0]      req1_funct3;
    logic            rsp_valid;
    logic            rsp_ready;
    logic            rsp_id;
    logic            rsp_eq;
    logic            rsp_lt;
    logic            rsp_taken;
    logic            rsp_illegal;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_funct3,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_funct3,
        output req1_ready,
        output rsp_valid, rsp_id, rsp_eq, rsp_lt,
        output rsp_taken, rsp_illegal,
        input  rsp_ready
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_funct3,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_funct3,
        input  req1_ready,
        input  rsp_valid, rsp_id, rsp_eq, rsp_lt,
        input  rsp_taken, rsp_illegal,
        output rsp_ready
    );
endinterface

// File: rtl/branch_comp_arbiter.sv
// One eq/lt comparator shared by the branch unit (id 0) and SLT path (id 1).
// Define BRCMP_ARB_RR_EN for round-robin ties; default is fixed priority.
module branch_comp_arbiter #(
    parameter int XLEN = 32
) (
    input logic                 clk,
    input logic                 rst,
    branch_comp_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMP  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic            w_gnt0;
    logic            w_gnt1;
    logic            w_rdy0;
    logic            w_rdy1;
    logic            w_fire;

    logic [XLEN-1:0] r_a;
    logic [XLEN-1:0] r_b;
    logic [2:0]      r_f3;
    logic            r_id;

    logic            w_eq;
    logic            w_lt;
    logic            w_uns;
    logic            w_taken;
    logic            w_illegal;

    logic            r_rsp_id;
    logic            r_rsp_eq;
    logic            r_rsp_lt;
    logic            r_rsp_taken;
    logic            r_rsp_illegal;

`ifdef BRCMP_ARB_RR_EN
    logic            r_last_grant;

    // Tie goes to whoever did not win last; req0 first after reset.
    assign w_gnt1 = bus.req1_valid &&
                    (!bus.req0_valid || !r_last_grant);

    // Remember the most recently accepted requester.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_grant <= 1'b1;
        end else if (w_fire) begin
            r_last_grant <= w_gnt1;
        end
    end
`else
    // Fixed priority: req1 only wins when req0 is idle.
    assign w_gnt1 = bus.req1_valid && !bus.req0_valid;
`endif

    assign w_gnt0 = bus.req0_valid && !w_gnt1;
    assign w_fire = w_rdy0 | w_rdy1;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and request-side ready.
    always_comb begin
        w_next = r_state;
        w_rdy0 = 1'b0;
        w_rdy1 = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_rdy0 = w_gnt0 && !rst;
                w_rdy1 = w_gnt1 && !rst;
                if (w_gnt0 || w_gnt1) begin
                    w_next = S_CMP;
                end
            end
            S_CMP: begin
                w_next = S_RESP;
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Capture the granted request's operands on handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a  <= '0;
            r_b  <= '0;
            r_f3 <= '0;
            r_id <= 1'b0;
        end else if (w_fire) begin
            r_a  <= w_gnt1 ? bus.req1_a : bus.req0_a;
            r_b  <= w_gnt1 ? bus.req1_b : bus.req0_b;
            r_f3 <= w_gnt1 ? bus.req1_funct3
                           : bus.req0_funct3;
            r_id <= w_gnt1;
        end
    end

    // Illegal 010/011 also has funct3[1] set but reports signed lt.
    assign w_uns     = r_f3[2] & r_f3[1];
    assign w_illegal = (r_f3[2:1] == 2'b01);
    assign w_eq      = (r_a == r_b);
    assign w_lt      = w_uns ? (r_a < r_b)
                             : ($signed(r_a) < $signed(r_b));

    // Resolve the branch condition from funct3.
    always_comb begin
        w_taken = 1'b0;
        case (r_f3)
            3'b000:  w_taken = w_eq;
            3'b001:  w_taken = !w_eq;
            3'b100:  w_taken = w_lt;
            3'b101:  w_taken = !w_lt;
            3'b110:  w_taken = w_lt;
            3'b111:  w_taken = !w_lt;
            default: w_taken = 1'b0;
        endcase
    end

    // Register the result in CMP; held through RESP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp_id      <= 1'b0;
            r_rsp_eq      <= 1'b0;
            r_rsp_lt      <= 1'b0;
            r_rsp_taken   <= 1'b0;
            r_rsp_illegal <= 1'b0;
        end else if (r_state == S_CMP) begin
            r_rsp_id      <= r_id;
            r_rsp_eq      <= w_eq;
            r_rsp_lt      <= w_lt;
            r_rsp_taken   <= w_taken;
            r_rsp_illegal <= w_illegal;
        end
    end

    assign bus.req0_ready  = w_rdy0;
    assign bus.req1_ready  = w_rdy1;
    assign bus.rsp_valid   = (r_state == S_RESP);
    assign bus.rsp_id      = r_rsp_id;
    assign bus.rsp_eq      = r_rsp_eq;
    assign bus.rsp_lt      = r_rsp_lt;
    assign bus.rsp_taken   = r_rsp_taken;
    assign bus.rsp_illegal = r_rsp_illegal;
endmodule

// File: tb/tb_branch_comp_arbiter.sv
// Directed bench for branch_comp_arbiter.
// Honors BRCMP_ARB_RR_EN for the arbitration-order expectations.
module tb_branch_comp_arbiter;
    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;

    branch_comp_arbiter_if #(.XLEN(32)) bus ();

    branch_comp_arbiter #(.XLEN(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h",
                   tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.req0_valid  = 1'b0;
        bus.req1_valid  = 1'b0;
    endtask

    task automatic do_req(input bit          who,
                          input logic [31:0] a,
                          input logic [31:0] b,
                          input logic [2:0]  f3,
                          input bit          e_eq,
                          input bit          e_lt,
                          input bit          e_tk,
                          input bit          e_il,
                          input string       tag);
        if (who) begin
            bus.req1_a      = a;
            bus.req1_b      = b;
            bus.req1_funct3 = f3;
            bus.req1_valid  = 1'b1;
        end else begin
            bus.req0_a      = a;
            bus.req0_b      = b;
            bus.req0_funct3 = f3;
            bus.req0_valid  = 1'b1;
        end
        bus.rsp_ready = 1'b1;
        #1;
        chk({tag, "_rdy0"}, bus.req0_ready, !who);
        chk({tag, "_rdy1"}, bus.req1_ready, who);
        tick();
        idle_inputs();
        chk({tag, "_cmp_vld"}, bus.rsp_valid, 0);
        tick();
        chk({tag, "_vld"}, bus.rsp_valid, 1);
        chk({tag, "_id"}, bus.rsp_id, who);
        chk({tag, "_eq"}, bus.rsp_eq, e_eq);
        chk({tag, "_lt"}, bus.rsp_lt, e_lt);
        chk({tag, "_tk"}, bus.rsp_taken, e_tk);
        chk({tag, "_il"}, bus.rsp_illegal, e_il);
        tick();
        chk({tag, "_idle"}, bus.rsp_valid, 0);
    endtask

    initial begin
        bit e_id;
        n_chk  = 0;
        n_fail = 0;

        // Reset state, valids high to prove ready is gated.
        rst             = 1'b1;
        bus.req0_valid  = 1'b1;
        bus.req1_valid  = 1'b1;
        bus.req0_a      = '0;
        bus.req0_b      = '0;
        bus.req0_funct3 = '0;
        bus.req1_a      = '0;
        bus.req1_b      = '0;
        bus.req1_funct3 = '0;
        bus.rsp_ready   = 1'b0;
        #12;
        chk("rst_rdy0", bus.req0_ready, 0);
        chk("rst_rdy1", bus.req1_ready, 0);
        chk("rst_vld", bus.rsp_valid, 0);
        chk("rst_tk", bus.rsp_taken, 0);
        idle_inputs();
        #2;
        rst = 1'b0;
        tick();
        chk("idle_vld", bus.rsp_valid, 0);

        // BEQ 5,5 and SLT/SLTU corner cases.
        do_req(0, 32'd5, 32'd5, 3'b000, 1, 0, 1, 0, "beq");
        do_req(1, 32'hFFFF_FFFF, 32'd1, 3'b100,
               0, 1, 1, 0, "blt_s");
        do_req(1, 32'hFFFF_FFFF, 32'd1, 3'b110,
               0, 0, 0, 0, "blt_u");
        do_req(0, 32'd0, 32'd0, 3'b011, 1, 0, 0, 1, "ill");
        do_req(0, 32'hFFFF_FFFF, 32'd1, 3'b010,
               0, 1, 0, 1, "ill_s");
        do_req(0, 32'd3, 32'd7, 3'b001, 0, 1, 1, 0, "bne");
        do_req(1, 32'd3, 32'd7, 3'b101, 0, 1, 0, 0, "bge");
        do_req(0, 32'd1, 32'hFFFF_FFFF, 3'b111,
               0, 1, 0, 0, "bgeu");

        // Fresh reset, then continuous contention.
        rst = 1'b1;
        #2;
        rst = 1'b0;
        tick();
        bus.req0_a      = 32'd1;
        bus.req0_b      = 32'd2;
        bus.req0_funct3 = 3'b100;
        bus.req1_a      = 32'd2;
        bus.req1_b      = 32'd1;
        bus.req1_funct3 = 3'b100;
        bus.req0_valid  = 1'b1;
        bus.req1_valid  = 1'b1;
        bus.rsp_ready   = 1'b1;
        for (int g = 0; g < 4; g++) begin
`ifdef BRCMP_ARB_RR_EN
            e_id = g[0];
`else
            e_id = 1'b0;
`endif
            #1;
            chk($sformatf("arb%0d_rdy0", g),
                bus.req0_ready, !e_id);
            chk($sformatf("arb%0d_rdy1", g),
                bus.req1_ready, e_id);
            tick();
            tick();
            chk($sformatf("arb%0d_id", g), bus.rsp_id, e_id);
            chk($sformatf("arb%0d_tk", g),
                bus.rsp_taken, !e_id);
            tick();
        end
        idle_inputs();
        tick();

        // Back-pressure: response held for 5 cycles.
        bus.req0_a      = 32'd7;
        bus.req0_b      = 32'd9;
        bus.req0_funct3 = 3'b110;
        bus.req0_valid  = 1'b1;
        bus.rsp_ready   = 1'b0;
        #1;
        chk("bp_rdy0", bus.req0_ready, 1);
        tick();
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        tick();
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("bp%0d_vld", c), bus.rsp_valid, 1);
            chk($sformatf("bp%0d_lt", c), bus.rsp_lt, 1);
            chk($sformatf("bp%0d_tk", c), bus.rsp_taken, 1);
            chk($sformatf("bp%0d_id", c), bus.rsp_id, 0);
            chk($sformatf("bp%0d_r0", c), bus.req0_ready, 0);
            chk($sformatf("bp%0d_r1", c), bus.req1_ready, 0);
            tick();
        end
        idle_inputs();
        bus.rsp_ready = 1'b1;
        #1;
        chk("bp_xfer_vld", bus.rsp_valid, 1);
        tick();
        chk("bp_done_vld", bus.rsp_valid, 0);
        tick();
        chk("bp_stay_idle", bus.rsp_valid, 0);

        // Reset while the request sits in CMP.
        bus.req1_a      = 32'd4;
        bus.req1_b      = 32'd4;
        bus.req1_funct3 = 3'b000;
        bus.req1_valid  = 1'b1;
        #1;
        chk("mid_rdy1", bus.req1_ready, 1);
        tick();
        idle_inputs();
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_vld", bus.rsp_valid, 0);
        #2;
        rst = 1'b0;
        tick();
        chk("mid_post1_vld", bus.rsp_valid, 0);
        tick();
        chk("mid_post2_vld", bus.rsp_valid, 0);

        // Post-reset tie must go to req0.
        bus.req1_a      = 32'd9;
        bus.req1_b      = 32'd1;
        bus.req1_funct3 = 3'b000;
        bus.req1_valid  = 1'b1;
        do_req(0, 32'd8, 32'd8, 3'b000, 1, 0, 1, 0, "post");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end
endmodule
